// File: rtl/uart_tx_fifo_ctrl.sv
// Character FIFO feeding a UART TX core through a launch/handshake FSM.
// Define UART_TX_FIFO_OVF_EN to add the sticky overflow flag (ovf / ovf_clr ports).
module uart_tx_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  input  logic                    tx_busy,
  output logic                    tx_data_valid,
  output logic [DATA_WIDTH-1:0]   tx_p_data
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic                    ovf,
  input  logic                    ovf_clr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW:0]           r_count;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  w_wr_acc;
  logic                  w_pop;

  // Flags derive from the registered count, so they move one edge after the cause.
  assign full      = (r_count == CNT_FULL);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign tx_p_data = r_tx_data;

  // A full FIFO drops the write even when a pop frees a slot on the same edge.
  assign w_wr_acc = wr_en && !full;
  assign w_pop    = (r_state == S_IDLE) && !empty && !tx_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_data <= '0;
    end else if (w_pop) begin
      r_tx_data <= r_mem[r_rptr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    tx_data_valid = 1'b0;
    case (r_state)
      S_IDLE:      if (w_pop) w_state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        tx_data_valid = 1'b1;
        w_state_nxt   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (tx_busy) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic r_ovf;

  // Clear wins over a coincident overflow so software never loses a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              r_ovf <= 1'b0;
    else if (ovf_clr)      r_ovf <= 1'b0;
    else if (wr_en && full) r_ovf <= 1'b1;
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: doc/uart_tx_fifo_ctrl.md
UART_TX_FIFO_CTRL -- requirements
Module: uart_tx_fifo_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of each queued character.
REQ-002 Parameter: DEPTH, 8, FIFO entries; power of two, minimum 2.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: wr_en  input  1  host write strobe; one character per high cycle.
REQ-006 Port: wr_data  input  DATA_WIDTH  character to enqueue.
REQ-007 Port: full  output  1  high when count equals DEPTH.
REQ-008 Port: empty  output  1  high when count equals 0.
REQ-009 Port: count  output  log2(DEPTH)+1  current occupancy.
REQ-010 Port: tx_busy  input  1  busy flag from the UART TX core.
REQ-011 Port: tx_data_valid  output  1  one-cycle launch pulse to the UART TX core.
REQ-012 Port: tx_p_data  output  DATA_WIDTH  character presented to the UART TX core.
REQ-013 Port: ovf  output  1  sticky overflow flag (UART_TX_FIFO_OVF_EN only).
REQ-014 Port: ovf_clr  input  1  clears ovf (UART_TX_FIFO_OVF_EN only).

Function
REQ-015 FIFO shall use circular read/write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 Write accepted only when wr_en=1 and full=0 in that cycle; write while full dropped, even if a pop occurs in the same cycle.
REQ-017 Accepted write and pop in the same cycle: count unchanged, both pointers advance.
REQ-018 full, empty and count shall update in the cycle after the causing edge (registered) and never be simultaneously high.
REQ-019 Launch FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE -> LAUNCH when empty=0 and tx_busy=0; otherwise remain in IDLE.
REQ-021 On the IDLE->LAUNCH edge, tx_p_data shall load the FIFO head and the read pointer shall advance (pop).
REQ-022 LAUNCH: tx_data_valid=1 for exactly that one cycle; next state WAIT_BUSY unconditionally.
REQ-023 WAIT_BUSY -> WAIT_DONE when tx_busy=1; otherwise remain in WAIT_BUSY.
REQ-024 WAIT_DONE -> IDLE when tx_busy=0; otherwise remain in WAIT_DONE.
REQ-025 tx_p_data shall hold its value from LAUNCH until the next IDLE->LAUNCH edge.
REQ-026 tx_data_valid shall be 0 in every state other than LAUNCH.
REQ-027 Minimum write-to-launch latency: write at edge N into an empty FIFO with FSM in IDLE and tx_busy=0 -> tx_data_valid=1 in cycle N+2.
REQ-028 Back-to-back characters: next launch shall not occur earlier than one cycle after tx_busy returns to 0.
REQ-029 Illegal FSM encodings shall return to IDLE on the next edge.

Reset
REQ-030 rst=0 shall immediately force: pointers 0, count 0, empty=1, full=0, FSM IDLE, tx_data_valid=0, tx_p_data=0, ovf=0.
REQ-031 Reset mid-transfer shall discard all queued characters; no launch in the first cycle after reset release.

Configuration
REQ-032 Macro UART_TX_FIFO_OVF_EN defined: ovf set on the edge after any write dropped by REQ-016; cleared by ovf_clr=1; ovf_clr has priority over a simultaneous set.
REQ-033 Macro UART_TX_FIFO_OVF_EN undefined: ovf and ovf_clr ports absent; dropped writes leave no trace.

Verification
REQ-034 Reset, then one write 0xA5 with tx_busy=0 -> tx_data_valid pulse 2 cycles later, tx_p_data=0xA5, empty=1 afterwards.
REQ-035 Eight writes 0x01..0x08 with tx_busy held 1 -> full=1, count=8; release tx_busy -> launches in order 0x01..0x08, each only after tx_busy rises then falls.
REQ-036 Ninth write 0x09 while full -> count stays 8, 0x09 never transmitted; with UART_TX_FIFO_OVF_EN ovf=1 until ovf_clr pulse, and ovf_clr coincident with a second overflow leaves ovf=0.
REQ-037 With count=8, simultaneous wr_en and pop -> write dropped, count=7; with count=3, simultaneous write and pop -> count stays 3, order preserved across pointer wrap after 20 total characters.
REQ-038 Assert rst=0 during WAIT_DONE with count=5 -> outputs at reset values immediately; after release with tx_busy=0 no tx_data_valid until a new write.
REQ-039 tx_busy never rises after LAUNCH -> FSM remains in WAIT_BUSY, no further tx_data_valid pulses, writes still accepted up to full.
